// File: rtl/div_sequencer.sv
// div_sequencer: multi-cycle RV32M divide unit (DIV, DIVU, REM, REMU).
// Borrows the execute-stage ALU for negation, compare and subtract, and runs
// restoring division one quotient bit per iteration.
// Build option: LOOPYV_DIV_FUSE_EN adds a one-entry result cache so that a
// REM following a DIV (or vice versa) on the same operands completes at once.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | ready for a request; special cases and cache hits go to DONE
// NEG_A | take magnitude of a negative signed dividend
// NEG_B | take magnitude of a negative signed divisor, clear rem/count
// CMP   | shift in next dividend bit, compare partial remainder to divisor
// SUB   | subtract divisor from partial remainder (quotient bit was 1)
// FIX   | pick quotient/remainder, apply sign correction
// DONE  | result valid, held until writeback accepts
module div_sequencer #(
    parameter int XLEN   = 32,
    parameter int ITER_W = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            reqValid,
    output logic            reqReady,
    input  logic [1:0]      reqOp,
    input  logic [XLEN-1:0] reqRs1,
    input  logic [XLEN-1:0] reqRs2,
    output logic            respValid,
    input  logic            respReady,
    output logic [XLEN-1:0] respData,
    output logic            aluOwn,
    output logic [XLEN-1:0] aluOperand1,
    output logic [XLEN-1:0] aluOperand2,
    output logic [3:0]      aluCntrl,
    input  logic [XLEN-1:0] aluResult
);

    // ALU operation encodings shared with the execute-stage ALU
    localparam logic [3:0] ALU_ADD  = 4'h0;
    localparam logic [3:0] ALU_SLTU = 4'h3;
    localparam logic [3:0] ALU_SUB  = 4'h8;

    localparam logic [XLEN-1:0]   MIN_NEG   = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0]   ALL_ONES  = {XLEN{1'b1}};
    localparam logic [ITER_W-1:0] LAST_ITER = ITER_W'(XLEN-1);

    typedef enum logic [2:0] {
        IDLE,
        NEG_A,
        NEG_B,
        CMP,
        SUB,
        FIX,
        DONE
    } state_t;

    state_t state, next_state;

    logic              is_rem;
    logic              sgn_q;
    logic              neg_q;
    logic              neg_r;
    logic [XLEN-1:0]   dvd;
    logic [XLEN-1:0]   dvs;
    logic [XLEN-1:0]   quo;
    logic [XLEN-1:0]   rem;
    logic [ITER_W-1:0] count;
    logic [XLEN-1:0]   resp_data;

    logic              req_signed;
    logic              div_zero;
    logic              div_ovf;
    logic              cache_hit;
    logic [XLEN-1:0]   shifted;
    logic              ge;
    logic [XLEN-1:0]   fix_sel;
    logic              fix_neg;
    logic [XLEN-1:0]   fix_res;

    assign req_signed = ~reqOp[0];
    assign div_zero   = (reqRs2 == '0);
    assign div_ovf    = req_signed && (reqRs1 == MIN_NEG) && (reqRs2 == ALL_ONES);

    // The bit shifted out of rem is the 33rd remainder bit; if set, the
    // shifted remainder certainly exceeds the divisor.
    assign shifted = {rem[XLEN-2:0], quo[XLEN-1]};
    assign ge      = rem[XLEN-1] | ~aluResult[0];

    assign fix_sel = is_rem ? rem : quo;
    assign fix_neg = is_rem ? neg_r : neg_q;
    assign fix_res = fix_neg ? aluResult : fix_sel;

    assign reqReady  = (state == IDLE);
    assign respValid = (state == DONE);
    assign respData  = resp_data;

`ifdef LOOPYV_DIV_FUSE_EN
    logic            c_valid;
    logic [XLEN-1:0] c_rs1;
    logic [XLEN-1:0] c_rs2;
    logic            c_sgn;
    logic [XLEN-1:0] c_q;
    logic [XLEN-1:0] c_r;
    logic [XLEN-1:0] orig_rs1;
    logic [XLEN-1:0] orig_rs2;
    logic [XLEN-1:0] fin_q;
    logic [XLEN-1:0] fin_r;

    assign cache_hit = c_valid && (c_rs1 == reqRs1) && (c_rs2 == reqRs2) &&
                       (c_sgn == req_signed);

    // Track both signed results of the current op and refill the cache when
    // writeback takes the result. The ALU only negates the selected result,
    // so the other one is sign-corrected locally for the cache.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            c_valid  <= 1'b0;
            c_rs1    <= '0;
            c_rs2    <= '0;
            c_sgn    <= 1'b0;
            c_q      <= '0;
            c_r      <= '0;
            orig_rs1 <= '0;
            orig_rs2 <= '0;
            fin_q    <= '0;
            fin_r    <= '0;
        end else begin
            if (state == IDLE && reqValid) begin
                orig_rs1 <= reqRs1;
                orig_rs2 <= reqRs2;
                if (div_zero) begin
                    fin_q <= ALL_ONES;
                    fin_r <= reqRs1;
                end else if (div_ovf) begin
                    fin_q <= MIN_NEG;
                    fin_r <= '0;
                end else if (cache_hit) begin
                    fin_q <= c_q;
                    fin_r <= c_r;
                end
            end
            if (state == FIX) begin
                if (is_rem) begin
                    fin_r <= fix_res;
                    fin_q <= neg_q ? (XLEN'(0) - quo) : quo;
                end else begin
                    fin_q <= fix_res;
                    fin_r <= neg_r ? (XLEN'(0) - rem) : rem;
                end
            end
            if (state == DONE && respReady) begin
                c_valid <= 1'b1;
                c_rs1   <= orig_rs1;
                c_rs2   <= orig_rs2;
                c_sgn   <= sgn_q;
                c_q     <= fin_q;
                c_r     <= fin_r;
            end
        end
    end
`else
    assign cache_hit = 1'b0;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next state and ALU request for the current step
    always_comb begin
        next_state  = state;
        aluOwn      = 1'b0;
        aluOperand1 = '0;
        aluOperand2 = '0;
        aluCntrl    = ALU_ADD;
        case (state)
            IDLE: begin
                if (reqValid) begin
                    next_state = (div_zero || div_ovf || cache_hit) ? DONE : NEG_A;
                end
            end
            NEG_A: begin
                aluOwn = 1'b1;
                if (sgn_q && dvd[XLEN-1]) begin
                    aluCntrl    = ALU_SUB;
                    aluOperand2 = dvd;
                end
                next_state = NEG_B;
            end
            NEG_B: begin
                aluOwn = 1'b1;
                if (sgn_q && dvs[XLEN-1]) begin
                    aluCntrl    = ALU_SUB;
                    aluOperand2 = dvs;
                end
                next_state = CMP;
            end
            CMP: begin
                aluOwn      = 1'b1;
                aluCntrl    = ALU_SLTU;
                aluOperand1 = shifted;
                aluOperand2 = dvs;
                if (ge) begin
                    next_state = SUB;
                end else if (count == LAST_ITER) begin
                    next_state = FIX;
                end else begin
                    next_state = CMP;
                end
            end
            SUB: begin
                aluOwn      = 1'b1;
                aluCntrl    = ALU_SUB;
                aluOperand1 = rem;
                aluOperand2 = dvs;
                next_state  = (count == LAST_ITER) ? FIX : CMP;
            end
            FIX: begin
                aluOwn = 1'b1;
                if (fix_neg) begin
                    aluCntrl    = ALU_SUB;
                    aluOperand2 = fix_sel;
                end
                next_state = DONE;
            end
            DONE: begin
                if (respReady) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Operand capture, iteration datapath and result register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            is_rem    <= 1'b0;
            sgn_q     <= 1'b0;
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
            dvd       <= '0;
            dvs       <= '0;
            quo       <= '0;
            rem       <= '0;
            count     <= '0;
            resp_data <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (reqValid) begin
                        is_rem <= reqOp[1];
                        sgn_q  <= req_signed;
                        dvd    <= reqRs1;
                        dvs    <= reqRs2;
                        neg_q  <= req_signed && (reqRs1[XLEN-1] ^ reqRs2[XLEN-1]) && !div_zero;
                        neg_r  <= req_signed && reqRs1[XLEN-1];
                        if (div_zero) begin
                            resp_data <= reqOp[1] ? reqRs1 : ALL_ONES;
                        end else if (div_ovf) begin
                            resp_data <= reqOp[1] ? '0 : MIN_NEG;
                        end
`ifdef LOOPYV_DIV_FUSE_EN
                        else if (cache_hit) begin
                            resp_data <= reqOp[1] ? c_r : c_q;
                        end
`endif
                    end
                end
                NEG_A: begin
                    if (sgn_q && dvd[XLEN-1]) begin
                        dvd <= aluResult;
                    end
                end
                NEG_B: begin
                    if (sgn_q && dvs[XLEN-1]) begin
                        dvs <= aluResult;
                    end
                    rem   <= '0;
                    count <= '0;
                    quo   <= dvd;
                end
                CMP: begin
                    rem <= shifted;
                    quo <= {quo[XLEN-2:0], ge};
                    if (!ge) begin
                        count <= count + 1'b1;
                    end
                end
                SUB: begin
                    rem   <= aluResult;
                    count <= count + 1'b1;
                end
                FIX: begin
                    resp_data <= fix_res;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_div_sequencer.sv
// tb_div_sequencer: directed and random checks of div_sequencer against an
// arithmetic reference model; the bench also models the execute-stage ALU.
module tb_div_sequencer;

    localparam logic [3:0] ALU_ADD  = 4'h0;
    localparam logic [3:0] ALU_SLTU = 4'h3;
    localparam logic [3:0] ALU_SUB  = 4'h8;

    logic        clk;
    logic        rst_n;
    logic        reqValid;
    logic        reqReady;
    logic [1:0]  reqOp;
    logic [31:0] reqRs1;
    logic [31:0] reqRs2;
    logic        respValid;
    logic        respReady;
    logic [31:0] respData;
    logic        aluOwn;
    logic [31:0] aluOperand1;
    logic [31:0] aluOperand2;
    logic [3:0]  aluCntrl;
    logic [31:0] aluResult;

    int n_checks = 0;
    int n_fail   = 0;

    // reference-model result cache (only consulted when the fuse build is on)
    bit          m_valid = 1'b0;
    logic [31:0] m_rs1, m_rs2, m_q, m_r;
    bit          m_sgn;

    div_sequencer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .reqValid   (reqValid),
        .reqReady   (reqReady),
        .reqOp      (reqOp),
        .reqRs1     (reqRs1),
        .reqRs2     (reqRs2),
        .respValid  (respValid),
        .respReady  (respReady),
        .respData   (respData),
        .aluOwn     (aluOwn),
        .aluOperand1(aluOperand1),
        .aluOperand2(aluOperand2),
        .aluCntrl   (aluCntrl),
        .aluResult  (aluResult)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // execute-stage ALU model
    always_comb begin
        case (aluCntrl)
            ALU_ADD:  aluResult = aluOperand1 + aluOperand2;
            ALU_SUB:  aluResult = aluOperand1 - aluOperand2;
            ALU_SLTU: aluResult = {31'd0, aluOperand1 < aluOperand2};
            default:  aluResult = 32'd0;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Plain-arithmetic reference: RISC-V division semantics, latency from the
    // number of one bits in the magnitude quotient.
    task automatic ref_div(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] q, output logic [31:0] r,
                           output int full_busy, output bit special);
        longint sa, sb, q64, r64, mag;
        bit sgn;
        sgn = !op[0];
        special = 1'b0;
        full_busy = 0;
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
            special = 1'b1;
        end else if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000;
            r = 32'd0;
            special = 1'b1;
        end else begin
            sa  = sgn ? longint'($signed(a)) : longint'({32'd0, a});
            sb  = sgn ? longint'($signed(b)) : longint'({32'd0, b});
            q64 = sa / sb;
            r64 = sa % sb;
            q   = q64[31:0];
            r   = r64[31:0];
            mag = (q64 < 0) ? -q64 : q64;
            full_busy = 35 + $countones(mag[31:0]);
        end
    endtask

    function automatic int fb(input int full);
`ifdef LOOPYV_DIV_FUSE_EN
        return 0;
`else
        return full;
`endif
    endfunction

    // One request/response transaction; busy = cycles between accept and
    // respValid, all of which must have aluOwn high.
    task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_res,
                          input int exp_busy, input int hold);
        logic [31:0] q, r;
        int full, busy, own, w;
        bit sp;
        w = 0;
        while (!reqReady && w < 100) begin
            @(posedge clk); #1;
            w++;
        end
        check({tag, "/ready"}, {31'd0, reqReady}, 32'd1);
        reqValid = 1'b1;
        reqOp    = op;
        reqRs1   = a;
        reqRs2   = b;
        @(posedge clk); #1;
        reqValid = 1'b0;
        busy = 0;
        own  = 0;
        while (!respValid && busy < 200) begin
            if (aluOwn) own++;
            busy++;
            @(posedge clk); #1;
        end
        check({tag, "/busy"}, 32'(busy), 32'(exp_busy));
        check({tag, "/own"}, 32'(own), 32'(exp_busy));
        check({tag, "/data"}, respData, exp_res);
        check({tag, "/done_own"}, {31'd0, aluOwn}, 32'd0);
        check({tag, "/done_ready"}, {31'd0, reqReady}, 32'd0);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check({tag, "/hold_data"}, respData, exp_res);
            check({tag, "/hold_valid"}, {31'd0, respValid}, 32'd1);
            check({tag, "/hold_ready"}, {31'd0, reqReady}, 32'd0);
        end
        respReady = 1'b1;
        @(posedge clk); #1;
        respReady = 1'b0;
        check({tag, "/idle_ready"}, {31'd0, reqReady}, 32'd1);
        check({tag, "/idle_valid"}, {31'd0, respValid}, 32'd0);
        ref_div(op, a, b, q, r, full, sp);
        m_valid = 1'b1;
        m_rs1 = a;
        m_rs2 = b;
        m_sgn = !op[0];
        m_q = q;
        m_r = r;
    endtask

    initial begin
        logic [1:0]  op;
        logic [31:0] a, b, q, r, exp_res;
        int full, exp_busy, sel;
        bit sp, hit;

        rst_n     = 1'b0;
        reqValid  = 1'b0;
        respReady = 1'b0;
        reqOp     = 2'd0;
        reqRs1    = 32'd0;
        reqRs2    = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        check("rst/ready", {31'd0, reqReady}, 32'd1);
        check("rst/valid", {31'd0, respValid}, 32'd0);
        check("rst/own", {31'd0, aluOwn}, 32'd0);
        check("rst/data", respData, 32'd0);
        check("rst/cntrl", {28'd0, aluCntrl}, {28'd0, ALU_ADD});
        check("rst/opnd1", aluOperand1, 32'd0);
        check("rst/opnd2", aluOperand2, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // normal unsigned and signed divisions
        run_op("divu_100_7", 2'b01, 32'd100, 32'd7, 32'd14, 38, 0);
        run_op("remu_100_7", 2'b11, 32'd100, 32'd7, 32'd2, fb(38), 0);
        run_op("div_m7_2", 2'b00, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 37, 0);
        run_op("rem_m7_2", 2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, fb(37), 0);
        run_op("div_7_m2", 2'b00, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 37, 0);

        // special cases: one cycle, ALU untouched
        run_op("divu_5_0", 2'b01, 32'd5, 32'd0, 32'hFFFF_FFFF, 0, 0);
        run_op("remu_5_0", 2'b11, 32'd5, 32'd0, 32'd5, 0, 0);
        run_op("div_ovf", 2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0, 0);
        run_op("rem_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 0, 0);

        // writeback back-pressure
        run_op("hold10", 2'b01, 32'd1000, 32'd10, 32'd100, 38, 10);

        // reset in the middle of the iteration loop
        reqValid = 1'b1;
        reqOp    = 2'b01;
        reqRs1   = 32'hFFFF_FFFF;
        reqRs2   = 32'd3;
        @(posedge clk); #1;
        reqValid = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        check("midrst/busy_own", {31'd0, aluOwn}, 32'd1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        m_valid = 1'b0;
        check("midrst/valid", {31'd0, respValid}, 32'd0);
        check("midrst/ready", {31'd0, reqReady}, 32'd1);
        check("midrst/own", {31'd0, aluOwn}, 32'd0);
        run_op("divu_9_3", 2'b01, 32'd9, 32'd3, 32'd3, 37, 0);

`ifdef LOOPYV_DIV_FUSE_EN
        run_op("fuse_div", 2'b00, 32'd1000, 32'hFFFF_FFF6, 32'hFFFF_FF9C, 38, 0);
        run_op("fuse_rem_hit", 2'b10, 32'd1000, 32'hFFFF_FFF6, 32'd0, 0, 0);
        run_op("fuse_rem_miss", 2'b10, 32'd1000, 32'hFFFF_FFF5, 32'd10, 39, 0);
`endif

        // random operations against the reference model
        for (int n = 0; n < 24; n++) begin
            op  = 2'($urandom_range(0, 3));
            a   = $urandom;
            sel = $urandom_range(0, 9);
            case (sel)
                0: b = 32'd0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: b = $urandom_range(1, 15);
                3: b = $urandom;
                default: b = $urandom >> $urandom_range(0, 31);
            endcase
            ref_div(op, a, b, q, r, full, sp);
            exp_res = op[1] ? r : q;
            hit = 1'b0;
`ifdef LOOPYV_DIV_FUSE_EN
            hit = m_valid && (m_rs1 == a) && (m_rs2 == b) && (m_sgn == !op[0]);
`endif
            exp_busy = (sp || hit) ? 0 : full;
            run_op($sformatf("rand%0d", n), op, a, b, exp_res, exp_busy, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
